// File: rtl/semaforo_monitor_seguranca_if.sv
// rtl/semaforo_monitor_seguranca_if.sv - controller-to-lamp bus of the traffic-light safety monitor
interface semaforo_monitor_seguranca_if;
    logic [41:0] lights_in;
    logic        fault_clr;
    logic [41:0] lamp_out;
    logic        fault;
    logic [2:0]  fault_code;

    modport master (
        output lights_in,
        output fault_clr,
        input  lamp_out,
        input  fault,
        input  fault_code
    );

    modport slave (
        input  lights_in,
        input  fault_clr,
        output lamp_out,
        output fault,
        output fault_code
    );
endinterface

// File: rtl/semaforo_monitor_seguranca.sv
// rtl/semaforo_monitor_seguranca.sv - safety monitor and registered lamp driver for 4 vehicle and 10 pedestrian heads
module semaforo_monitor_seguranca #(
    parameter int FILT       = 2,
    parameter int GREEN_MAX  = 40,
    parameter int BLINK_HALF = 8
) (
    input logic                          clk,
    input logic                          rst,
    semaforo_monitor_seguranca_if.slave  bus
);

    localparam logic [2:0]  RED      = 3'b100;
    localparam logic [2:0]  YEL      = 3'b010;
    localparam logic [2:0]  GRN      = 3'b001;
    localparam logic [41:0] ALL_RED  = {14{RED}};
    localparam logic [7:0]  GMAX8    = 8'(GREEN_MAX);
    localparam logic [7:0]  BHALF_M1 = 8'(BLINK_HALF - 1);
    localparam logic [3:0]  FILT4    = 4'(FILT);

    typedef enum logic {NORMAL, FAULT} state_t;

    state_t      state_q, state_d;
    logic [41:0] lamp_q, lamp_d;
    logic        fault_q, fault_d;
    logic [2:0]  code_q, code_d;
    logic [2:0]  filt_q, filt_d;
    logic        phase_q, phase_d;
    logic [7:0]  bcnt_q, bcnt_d;
    logic [7:0]  gcnt_q [4];
    logic [7:0]  gcnt_d [4];
    logic [11:0] prev_q, prev_d;

    logic [2:0]  slot [14];
    logic [13:0] act;
    logic        c1, c2, c3, c4, c12, confirm, veh_all_red;
    logic [2:0]  filt_inc;

    function automatic logic [41:0] flash(input logic on);
        flash = {30'b0, on ? {4{YEL}} : 12'b0};
    endfunction

    // Slot decode, invalid-code, transition and timeout detection.
    always_comb begin
        c1          = 1'b0;
        c3          = 1'b0;
        c4          = 1'b0;
        veh_all_red = 1'b1;
        act         = '0;
        for (int k = 0; k < 14; k++) begin
            slot[k] = bus.lights_in[3*k +: 3];
            act[k]  = (slot[k] == YEL) || (slot[k] == GRN);
            if ((slot[k] != RED) && !act[k]) c1 = 1'b1;
        end
        for (int v = 0; v < 4; v++) begin
            if (((prev_q[3*v +: 3] == GRN) && (slot[v] == RED)) ||
                ((prev_q[3*v +: 3] == RED) && (slot[v] == YEL)) ||
                ((prev_q[3*v +: 3] == YEL) && (slot[v] == GRN)))
                c3 = 1'b1;
            if ((slot[v] == GRN) && (gcnt_q[v] >= GMAX8)) c4 = 1'b1;
            if (slot[v] != RED) veh_all_red = 1'b0;
        end
    end

    // Slots 0/2 are F1/F6 (group A), 1/3 are F2/F9 (group B); 8 and 13 (P5, P10) conflict with both.
    assign c2 = ((act[0] | act[2]) &
                 (act[1] | act[3] | act[4] | act[6] | act[8] | act[9] | act[11] | act[13])) |
                ((act[1] | act[3]) &
                 (act[0] | act[2] | act[5] | act[7] | act[8] | act[10] | act[12] | act[13]));

    assign c12      = c1 | c2;
    assign filt_inc = (filt_q == 3'd7) ? 3'd7 : filt_q + 3'd1;
    assign confirm  = c12 && (({1'b0, filt_q} + 4'd1) >= FILT4);

    always_comb begin
        state_d = state_q;
        lamp_d  = lamp_q;
        fault_d = fault_q;
        code_d  = code_q;
        filt_d  = filt_q;
        phase_d = phase_q;
        bcnt_d  = bcnt_q;
        // Glitched samples are not trusted as sequencing history.
        prev_d  = c12 ? prev_q : bus.lights_in[11:0];
        for (int v = 0; v < 4; v++) begin
            if (slot[v] == GRN)
                gcnt_d[v] = (gcnt_q[v] == 8'hff) ? 8'hff : gcnt_q[v] + 8'd1;
            else
                gcnt_d[v] = 8'd0;
        end

        case (state_q)
            NORMAL: begin
                filt_d = c12 ? filt_inc : 3'd0;
                if (confirm || c3 || c4) begin
                    state_d = FAULT;
                    fault_d = 1'b1;
                    filt_d  = 3'd0;
                    phase_d = 1'b1;
                    bcnt_d  = 8'd0;
                    lamp_d  = flash(1'b1);
                    if (confirm)
                        code_d = c1 ? 3'd1 : 3'd2;
                    else if (c3)
                        code_d = 3'd3;
                    else
                        code_d = 3'd4;
                end else if (!c12) begin
                    lamp_d = bus.lights_in;
                end
            end
            FAULT: begin
                if (bus.fault_clr && veh_all_red && !c1) begin
                    state_d = NORMAL;
                    fault_d = 1'b0;
                    code_d  = 3'd0;
                    filt_d  = 3'd0;
                    for (int v = 0; v < 4; v++) gcnt_d[v] = 8'd0;
                    lamp_d  = bus.lights_in;
                end else begin
                    if (bcnt_q == BHALF_M1) begin
                        phase_d = !phase_q;
                        bcnt_d  = 8'd0;
                    end else begin
                        bcnt_d  = bcnt_q + 8'd1;
                    end
                    lamp_d = flash(phase_d);
                end
            end
            default: state_d = NORMAL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= NORMAL;
            lamp_q  <= ALL_RED;
            fault_q <= 1'b0;
            code_q  <= 3'd0;
            filt_q  <= 3'd0;
            phase_q <= 1'b0;
            bcnt_q  <= 8'd0;
            prev_q  <= ALL_RED[11:0];
            for (int v = 0; v < 4; v++) gcnt_q[v] <= 8'd0;
        end else begin
            state_q <= state_d;
            lamp_q  <= lamp_d;
            fault_q <= fault_d;
            code_q  <= code_d;
            filt_q  <= filt_d;
            phase_q <= phase_d;
            bcnt_q  <= bcnt_d;
            prev_q  <= prev_d;
            for (int v = 0; v < 4; v++) gcnt_q[v] <= gcnt_d[v];
        end
    end

    assign bus.lamp_out   = lamp_q;
    assign bus.fault      = fault_q;
    assign bus.fault_code = code_q;

endmodule

// File: tb/tb_semaforo_monitor_seguranca.sv
// tb/tb_semaforo_monitor_seguranca.sv - self-checking bench for the traffic-light safety monitor
module tb_semaforo_monitor_seguranca;

    localparam int FILT       = 2;
    localparam int GREEN_MAX  = 40;
    localparam int BLINK_HALF = 8;
    localparam logic [2:0]  R = 3'b100;
    localparam logic [2:0]  Y = 3'b010;
    localparam logic [2:0]  G = 3'b001;
    localparam logic [41:0] ALL_RED   = {14{R}};
    localparam logic [41:0] FLASH_ON  = {30'b0, Y, Y, Y, Y};
    localparam logic [41:0] FLASH_OFF = 42'b0;

    logic clk = 1'b0;
    logic rst;
    semaforo_monitor_seguranca_if bus ();

    semaforo_monitor_seguranca #(
        .FILT(FILT), .GREEN_MAX(GREEN_MAX), .BLINK_HALF(BLINK_HALF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [13:0] grp_a = 14'b11010110100101;
    logic [13:0] grp_b = 14'b10101101011010;

    logic [41:0] m_lamp;
    bit          m_fault;
    int          m_code, m_streak, m_cyc, m_latch;
    int          m_run [4];
    logic [2:0]  m_prev [4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [41:0] lts(input logic [2:0] f1, f2, f6, f9, input logic [9:0] pg);
        logic [29:0] p;
        for (int k = 0; k < 10; k++) p[3*k +: 3] = pg[k] ? G : R;
        return {p, f9, f6, f2, f1};
    endfunction

    function automatic logic [41:0] veh(input logic [2:0] f1, f2, f6, f9);
        return lts(f1, f2, f6, f9, 10'b0);
    endfunction

    function automatic logic [41:0] m_flash(input bit on);
        return on ? FLASH_ON : FLASH_OFF;
    endfunction

    task automatic model_reset();
        m_lamp = ALL_RED; m_fault = 0; m_code = 0; m_streak = 0; m_cyc = 0; m_latch = 0;
        for (int v = 0; v < 4; v++) begin m_run[v] = 0; m_prev[v] = R; end
    endtask

    // Reference behaviour written straight from the rules: group membership, run lengths, elapsed time.
    task automatic model_step(input logic [41:0] l, input bit c);
        logic [2:0] s [14];
        bit act [14];
        bit inv, conf, trans, tmo, all_red;
        int cause;
        inv = 0; conf = 0; trans = 0; tmo = 0; all_red = 1; cause = 0;
        m_cyc++;
        for (int k = 0; k < 14; k++) begin
            s[k] = l[3*k +: 3];
            act[k] = (s[k] == Y) || (s[k] == G);
            if (!(s[k] == R || s[k] == Y || s[k] == G)) inv = 1;
        end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 14; j++)
                if (act[i] && act[j] && ((grp_a[i] && grp_b[j]) || (grp_b[i] && grp_a[j]))) conf = 1;
        for (int v = 0; v < 4; v++) begin
            if ((m_prev[v] == G && s[v] == R) || (m_prev[v] == R && s[v] == Y) ||
                (m_prev[v] == Y && s[v] == G)) trans = 1;
            if (s[v] == G && m_run[v] >= GREEN_MAX) tmo = 1;
            if (s[v] != R) all_red = 0;
            m_run[v] = (s[v] == G) ? m_run[v] + 1 : 0;
        end
        if (!inv && !conf) for (int v = 0; v < 4; v++) m_prev[v] = s[v];
        if (!m_fault) begin
            m_streak = (inv || conf) ? m_streak + 1 : 0;
            if ((inv || conf) && m_streak >= FILT) cause = inv ? 1 : 2;
            else if (trans) cause = 3;
            else if (tmo) cause = 4;
            if (cause != 0) begin
                m_fault = 1; m_code = cause; m_latch = m_cyc; m_streak = 0; m_lamp = m_flash(1);
            end else if (!(inv || conf)) begin
                m_lamp = l;
            end
        end else if (c && all_red && !inv) begin
            m_fault = 0; m_code = 0; m_streak = 0; m_lamp = l;
            for (int v = 0; v < 4; v++) m_run[v] = 0;
        end else begin
            m_lamp = m_flash(((m_cyc - m_latch) / BLINK_HALF) % 2 == 0);
        end
    endtask

    task automatic cyc(input logic [41:0] l, input logic c);
        bus.lights_in = l;
        bus.fault_clr = c;
        @(posedge clk);
        #1;
        model_step(l, c);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.lights_in = ALL_RED;
        bus.fault_clr = 1'b0;
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic chk_state(input string name, input logic [41:0] lamp, input logic f, input logic [2:0] code);
        chk({name, ".lamp"}, bus.lamp_out, lamp);
        chk({name, ".fault"}, bus.fault, f);
        chk({name, ".code"}, bus.fault_code, code);
    endtask

    typedef struct packed {
        logic [41:0] l;
        logic        clr;
        logic [41:0] lamp;
        logic        flt;
        logic [2:0]  code;
    } vec_t;

    vec_t        tbl [8];
    logic [41:0] pool [7];
    logic [41:0] s1, s2, s3, s4, s5, s6;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [41:0] cur;
        int idx, len;
        s1 = lts(G, R, G, R, 10'b0101001010);
        s2 = lts(Y, R, Y, R, 10'b0);
        s3 = ALL_RED;
        s4 = lts(R, G, R, G, 10'b0010100101);
        s5 = lts(R, Y, R, Y, 10'b0);
        s6 = lts(R, R, R, R, 10'b1000010000);
        pool[0] = s1; pool[1] = s2; pool[2] = s3; pool[3] = s4;
        pool[4] = s5; pool[5] = s6; pool[6] = ALL_RED;

        tbl[0] = '{veh(G, R, R, R), 1'b0, veh(G, R, R, R), 1'b0, 3'd0};
        tbl[1] = '{veh(G, G, R, R), 1'b0, veh(G, R, R, R), 1'b0, 3'd0};
        tbl[2] = '{veh(G, R, R, R), 1'b0, veh(G, R, R, R), 1'b0, 3'd0};
        tbl[3] = '{veh(Y, R, R, R), 1'b0, veh(Y, R, R, R), 1'b0, 3'd0};
        tbl[4] = '{ALL_RED,         1'b0, ALL_RED,         1'b0, 3'd0};
        tbl[5] = '{s6,              1'b0, s6,              1'b0, 3'd0};
        tbl[6] = '{lts(R, R, 3'b011, R, 10'b1000010000), 1'b0, s6, 1'b0, 3'd0};
        tbl[7] = '{ALL_RED,         1'b0, ALL_RED,         1'b0, 3'd0};

        do_reset();
        chk_state("reset", ALL_RED, 1'b0, 3'd0);

        for (int i = 0; i < 8; i++) begin
            cyc(tbl[i].l, tbl[i].clr);
            chk_state($sformatf("vec%0d", i), tbl[i].lamp, tbl[i].flt, tbl[i].code);
        end

        // Full controller cycle, twice: pure 1-cycle pass-through, never a fault.
        for (int rep = 0; rep < 2; rep++) begin
            for (int ph = 0; ph < 6; ph++) begin
                case (ph)
                    0: begin cur = s1; len = 31; end
                    1: begin cur = s2; len = 3;  end
                    2: begin cur = s3; len = 2;  end
                    3: begin cur = s4; len = 31; end
                    4: begin cur = s5; len = 3;  end
                    default: begin cur = s6; len = 10; end
                endcase
                for (int t = 0; t < len; t++) begin
                    cyc(cur, 1'b0);
                    chk($sformatf("ctl_s%0d_lamp", ph + 1), bus.lamp_out, cur);
                    chk($sformatf("ctl_s%0d_fault", ph + 1), bus.fault, 1'b0);
                end
            end
        end
        cyc(ALL_RED, 1'b0);

        // Conflict held for FILT cycles, then the flash pattern and clear handling.
        cyc(veh(G, R, R, R), 1'b0);
        cyc(veh(G, G, R, R), 1'b0);
        chk_state("conf_hold", veh(G, R, R, R), 1'b0, 3'd0);
        cyc(veh(G, G, R, R), 1'b0);
        chk_state("conf_latch", FLASH_ON, 1'b1, 3'd2);
        for (int i = 1; i < 16; i++) begin
            cyc(veh(G, G, R, R), 1'b0);
            chk($sformatf("flash_%0d", i), bus.lamp_out, (i < 8) ? FLASH_ON : FLASH_OFF);
        end
        cyc(veh(G, R, R, R), 1'b0);
        chk("flash_16", bus.lamp_out, FLASH_ON);
        cyc(veh(G, R, R, R), 1'b1);
        chk_state("clr_ignored", FLASH_ON, 1'b1, 3'd2);
        cyc(ALL_RED, 1'b1);
        chk_state("clr_ok", ALL_RED, 1'b0, 3'd0);
        cyc(ALL_RED, 1'b0);
        chk_state("after_clr", ALL_RED, 1'b0, 3'd0);

        // Green straight to red.
        cyc(veh(G, R, R, R), 1'b0);
        cyc(ALL_RED, 1'b0);
        chk_state("g2r", FLASH_ON, 1'b1, 3'd3);
        cyc(ALL_RED, 1'b1);
        chk_state("g2r_clr", ALL_RED, 1'b0, 3'd0);

        // Illegal transition with an unconfirmed conflict: transition wins.
        cyc(veh(G, R, R, R), 1'b0);
        cyc(veh(R, G, G, R), 1'b0);
        chk_state("c3_with_c2", FLASH_ON, 1'b1, 3'd3);
        cyc(ALL_RED, 1'b1);

        // Conflict confirmed on the same cycle as an illegal transition: conflict wins.
        cyc(veh(G, R, R, R), 1'b0);
        cyc(veh(G, R, G, G), 1'b0);
        chk_state("c2_first", veh(G, R, R, R), 1'b0, 3'd0);
        cyc(veh(R, R, G, G), 1'b0);
        chk_state("c2_confirm", FLASH_ON, 1'b1, 3'd2);
        cyc(ALL_RED, 1'b1);
        chk_state("c2_clr", ALL_RED, 1'b0, 3'd0);

        // Green timeout on F2.
        for (int i = 1; i <= GREEN_MAX; i++) cyc(veh(R, G, R, R), 1'b0);
        chk_state("green_40", veh(R, G, R, R), 1'b0, 3'd0);
        cyc(veh(R, G, R, R), 1'b0);
        chk_state("green_41", FLASH_ON, 1'b1, 3'd4);

        // Asynchronous reset in the middle of the flash.
        for (int i = 0; i < 10; i++) cyc(veh(R, G, R, R), 1'b0);
        #2 rst = 1'b1;
        #1;
        chk_state("async_rst", ALL_RED, 1'b0, 3'd0);
        model_reset();
        bus.lights_in = ALL_RED;
        bus.fault_clr = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        // Randomised stimulus against the reference model.
        cur = ALL_RED;
        for (int n = 0; n < 1500; n++) begin
            logic [41:0] l;
            logic c;
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
                cur = ALL_RED;
            end
            if ($urandom_range(0, 3) == 0) cur = pool[$urandom_range(0, 6)];
            l = cur;
            if ($urandom_range(0, 9) == 0) begin
                idx = $urandom_range(0, 13);
                l[3*idx +: 3] = 3'($urandom);
            end
            if ($urandom_range(0, 49) == 0) l = {$urandom, $urandom};
            c = ($urandom_range(0, 3) == 0);
            if (m_fault && $urandom_range(0, 1) == 0) l = ALL_RED;
            cyc(l, c);
            chk("rnd_lamp", bus.lamp_out, m_lamp);
            chk("rnd_fault", bus.fault, m_fault);
            chk("rnd_code", bus.fault_code, 3'(m_code));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/semaforo_monitor_seguranca.md
# semaforo_monitor_seguranca

- Safety monitor and lamp driver placed directly downstream of the traffic-light controller.
- Samples the 14 light codes (F1, F2, F6, F9, P1..P10) every clock and passes them to the lamp outputs with one cycle of latency.
- Detects invalid encodings, conflicting greens, illegal vehicle sequencing and stuck greens.
- On a confirmed fault it latches into a fail-safe state: vehicle heads flash yellow, pedestrian heads go dark.

## Interface
- FILT, 2: consecutive cycles an encoding/conflict condition must persist before a fault latches (1..7).
- GREEN_MAX, 40: maximum consecutive cycles a vehicle head may show green (1..254).
- BLINK_HALF, 8: half-period of the fault flash, in cycles (1..255).
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- lights_in  in  42  controller codes. Slot k = bits [3k+2:3k]. Slot order: F1, F2, F6, F9, P1, P2, ..., P10. Codes: 100 red, 010 yellow, 001 green.
- fault_clr  in  1  request to leave the fault state; level-sampled.
- lamp_out  out  42  lamp drive, same packing as lights_in; registered.
- fault  out  1  high while in FAULT.
- fault_code  out  3  0 none, 1 invalid code, 2 conflict, 3 illegal vehicle transition, 4 green timeout.

## Operation
- Group A = {F1, F6, P2, P4, P7, P9}. Group B = {F2, F9, P1, P3, P6, P8}. P5 and P10 belong to both groups.
- "Active" means the head's code is 010 or 001.
- C1, invalid: any slot is not one of {100, 010, 001}.
- C2, conflict: any of the following holds.
  - F1 or F6 active and any of F2, F9, P1, P3, P5, P6, P8, P10 active.
  - F2 or F9 active and any of F1, F6, P2, P4, P5, P7, P9, P10 active.
- C3, illegal transition (vehicle slots only): previous sample → current sample is green→red, red→yellow or yellow→green. The previous-sample register resets to all-red. Pedestrian slots are not checked.
- C4, timeout: a vehicle head is sampled green on GREEN_MAX+1 consecutive cycles.
  - Each vehicle head has its own 8-bit saturating counter, cleared on any non-green sample.
- Filter counter: increments on each cycle where C1 or C2 holds; clears on a cycle where neither holds. A fault latches when it reaches FILT.
- C3 and C4 latch immediately, with no filter.
- Simultaneous conditions: fault_code takes the lowest-numbered condition present in the latching cycle.
- FSM NORMAL:
  - If no condition is present, lamp_out <= lights_in.
  - While C1/C2 is present but not yet confirmed, lamp_out holds its last value.
  - On latch: go to FAULT, fault <= 1, fault_code <= cause, blink phase <= on, blink counter <= 0.
- FSM FAULT:
  - Vehicle slots = 010 when blink phase is on, 000 when off.
  - All pedestrian slots = 000.
  - Blink phase toggles every BLINK_HALF cycles.
  - New conditions are ignored and fault_code is frozen.
- Exit FAULT only when fault_clr = 1 in a cycle where all four vehicle slots are 100 and C1 is false. Then go to NORMAL, fault <= 0, fault_code <= 0, and clear the filter and green counters.
  - fault_clr under any other input is ignored; remain in FAULT.

## Timing
- Reset values: lamp_out = all slots 100; fault = 0; fault_code = 0; FSM = NORMAL; all counters 0; previous sample all-red.
- Reset mid-FAULT returns to these values immediately (asynchronous).
- Pass-through latency is 1 cycle: lights_in sampled at edge n appears on lamp_out after edge n.
- C1/C2 first present at edge n and held:
  - fault = 1 and the flash pattern appear after edge n+FILT-1.
  - lamp_out holds from edge n.
- A condition lasting fewer than FILT cycles causes no fault.
  - lamp_out resumes pass-through on the first clean sample.
- C3/C4 detected at edge n: fault = 1 after edge n.
- Flash: the first on-phase lasts BLINK_HALF cycles starting with the latch edge, then alternates off/on.
- Clear accepted at edge n: lamp_out = lights_in after edge n.

## Test plan
- Full controller cycle (S1..S6, greens 31 cycles), defaults:
  - lamp_out equals lights_in delayed by 1 cycle throughout.
  - fault stays 0.
- F1 = 001 and F2 = 001 for 1 cycle, then legal:
  - No fault.
  - lamp_out holds for 1 cycle, then resumes.
- Same conflict held 2 cycles:
  - fault = 1 and fault_code = 2 after the second edge.
  - Vehicle slots show 010 for 8 cycles, then 000 for 8 cycles.
  - Pedestrian slots show 000.
- F1 changes 001 → 100 directly:
  - fault_code = 3 on the next cycle.
  - With a conflict also present in the same cycle, fault_code = 2 is reported only once the filter confirms; otherwise 3.
- F2 held green 41 cycles: fault_code = 4 after the 41st sample.
- In FAULT:
  - fault_clr with F1 = 001: ignored.
  - fault_clr with all vehicles red: NORMAL, fault = 0, code 0.
  - rst asserted mid-flash: lamp_out all 100 immediately.
